mc_control: RTL

Multicycle main-control FSM for the MIPS-lite datapath. It sequences each instruction through fetch, decode, execute, memory and writeback steps. It drives the per-step datapath enables and the 2-bit ALUOp pair consumed by the ALU control decoder. Memory steps use a ready handshake, so the shared instruction/data memory may take multiple cycles.

---
 rtl/mc_control.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mc_control.sv
// mc_control: multicycle MIPS-lite main-control FSM sequencing fetch/decode/execute/memory/writeback
module mc_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       memready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       aluop1,
  output logic       aluop0,
  output logic [1:0] pcsource,
  output logic       illegal_op,
  output logic [3:0] state
);
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    RWB    = 4'd8,
    BEQ    = 4'd9,
    JUMP   = 4'd10
  } state_t;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  state_t cur, nxt;
  logic [1:0] aluop;
  assign {aluop1, aluop0} = aluop;
  assign state = cur;
  // state register; async reset drops straight to IDLE so every output clears at once
  always_ff @(posedge clk or posedge reset)
    if (reset) cur <= IDLE;
    else cur <= nxt;
  // next-state and Moore outputs; FETCH pcwrite/irwrite and DECODE illegal_op are input-qualified
  always_comb begin
    nxt = IDLE;
    pcwrite = 1'b0;
    pcwritecond = 1'b0;
    iord = 1'b0;
    memread = 1'b0;
    memwrite = 1'b0;
    memtoreg = 1'b0;
    irwrite = 1'b0;
    regdst = 1'b0;
    regwrite = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    aluop = 2'b00;
    pcsource = 2'b00;
    illegal_op = 1'b0;
    case (cur)
      IDLE: nxt = FETCH;
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        pcwrite = memready;
        irwrite = memready;
        nxt = memready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
              (op == OP_R) ? EXEC :
              (op == OP_BEQ) ? BEQ :
              (op == OP_J) ? JUMP : FETCH;
        illegal_op = !(op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ || op == OP_J);
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nxt = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread = 1'b1;
        iord = 1'b1;
        nxt = memready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        nxt = FETCH;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord = 1'b1;
        nxt = memready ? FETCH : MEMWR;
      end
      EXEC: begin
        alusrca = 1'b1;
        aluop = 2'b10;
        nxt = RWB;
      end
      RWB: begin
        regwrite = 1'b1;
        regdst = 1'b1;
        nxt = FETCH;
      end
      BEQ: begin
        alusrca = 1'b1;
        aluop = 2'b01;
        pcwritecond = 1'b1;
        pcsource = 2'b01;
        nxt = FETCH;
      end
      JUMP: begin
        pcwrite = 1'b1;
        pcsource = 2'b10;
        nxt = FETCH;
      end
      default: nxt = IDLE;
    endcase
  end
endmodule
